// File: rtl/sha256_msg_ctrl.sv
// Multi-block SHA-256 sequencer: feeds pre-padded 512-bit blocks to a single-block
// core one at a time, chaining each result into the next block's initial hash.
module sha256_msg_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy,
  output logic         error,
  output logic         core_start,
  output logic [511:0] core_block,
  output logic [255:0] core_iv,
  input  logic [255:0] core_result,
  input  logic         core_done
);

  localparam logic [255:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT,
    ERR
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [255:0]  chain;
  logic [CW-1:0] cnt;
  logic          last_flag;
  logic          accept;
  logic          handoff;
  logic          counting;
  logic          expired;

  assign accept   = (state == IDLE) && blk_valid;
  assign handoff  = (state == OUT) && digest_ready;
  assign counting = (state == RUN) || (state == DRAIN);
  // A block may occupy RUN+DRAIN for at most TIMEOUT_CYCLES cycles; progress
  // in the final allowed cycle still wins over the timeout.
  assign expired  = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (blk_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (core_done) begin
          state_next = DRAIN;
        end else if (expired) begin
          state_next = ERR;
        end
      end
      DRAIN: begin
        if (!core_done) begin
          state_next = last_flag ? OUT : IDLE;
        end else if (expired) begin
          state_next = ERR;
        end
      end
      OUT: begin
        if (digest_ready) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_block <= '0;
      last_flag  <= 1'b0;
    end else if (accept) begin
      core_block <= blk_data;
      last_flag  <= blk_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (counting) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The chain reverts to the standard IV once the digest has been taken, so
  // the next accepted block always opens a fresh message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= SHA_IV;
    end else if (handoff) begin
      chain <= SHA_IV;
    end else if ((state == RUN) && core_done) begin
      chain <= core_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else if (accept) begin
      busy <= 1'b1;
    end else if (handoff) begin
      busy <= 1'b0;
    end
  end

  assign blk_ready    = (state == IDLE);
  assign core_start   = (state == RUN);
  assign digest_valid = (state == OUT);
  assign error        = (state == ERR);
  assign digest       = digest_valid ? chain : '0;
  assign core_iv      = chain;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Randomized scoreboard bench for sha256_msg_ctrl with a behavioural SHA-256 core
// stub; expected digests come from known vectors or a message-level reference.
module tb_sha256_msg_ctrl;

  localparam int TMO = 16;
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO_A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO_B = {480'h0, 32'h000001c0};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         digest_valid;
  logic         digest_ready;
  logic [255:0] digest;
  logic         busy;
  logic         error;
  logic         core_start;
  logic [511:0] core_block;
  logic [255:0] core_iv;
  logic [255:0] core_result;
  logic         core_done;

  int checks = 0;
  int fails = 0;
  logic [255:0] exp_q[$];
  logic [255:0] iv_q[$];
  logic [511:0] blk_q[$];
  int core_lat = 3;
  int stall_len = 0;
  int run_cnt;

  sha256_msg_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
    .busy(busy), .error(error),
    .core_start(core_start), .core_block(core_block), .core_iv(core_iv),
    .core_result(core_result), .core_done(core_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Plain FIPS 180-4 compression of one block from hash state h.
  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
             + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural single-block core: done rises core_lat cycles after start,
  // stays high while start is held, falls one cycle after start drops.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt     <= 0;
      core_done   <= 1'b0;
      core_result <= '0;
    end else if (core_start) begin
      run_cnt <= run_cnt + 1;
      if (run_cnt + 1 == core_lat) begin
        core_done   <= 1'b1;
        core_result <= sha_compress(core_iv, core_block);
      end
    end else begin
      run_cnt   <= 0;
      core_done <= 1'b0;
    end
  end

  initial begin : core_monitor
    bit seen = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start && !seen) begin
        seen = 1'b1;
        if (iv_q.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected core run: core_start=%0b with no block pending", core_start);
        end else begin
          checkOutput("core_iv", 512'(core_iv), 512'(iv_q.pop_front()));
          checkOutput("core_block", core_block, blk_q.pop_front());
        end
      end else if (!core_start) begin
        seen = 1'b0;
      end
    end
  end

  initial begin : digest_monitor
    bit pv = 1'b0;
    bit pr = 1'b0;
    int hold = 0;
    digest_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pv && pr && exp_q.size() != 0) void'(exp_q.pop_front());
      if (digest_valid) begin
        if (!pv) hold = stall_len;
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected digest: got %0h with none expected", digest);
        end else begin
          checkOutput("digest", 512'(digest), 512'(exp_q[0]));
        end
        if (hold > 0) begin
          digest_ready = 1'b0;
          hold--;
        end else begin
          digest_ready = 1'b1;
        end
      end else begin
        digest_ready = 1'($urandom_range(0, 1));
      end
      pv = digest_valid;
      pr = digest_ready;
    end
  end

  task automatic checkResetValues();
    checkOutput("reset blk_ready", 512'(blk_ready), 512'(1));
    checkOutput("reset core_start", 512'(core_start), 512'(0));
    checkOutput("reset digest_valid", 512'(digest_valid), 512'(0));
    checkOutput("reset busy", 512'(busy), 512'(0));
    checkOutput("reset error", 512'(error), 512'(0));
    checkOutput("reset digest", 512'(digest), 512'(0));
    checkOutput("reset core_block", core_block, 512'(0));
    checkOutput("reset core_iv", 512'(core_iv), 512'(IV));
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    checkResetValues();
    exp_q.delete();
    iv_q.delete();
    blk_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [511:0] d, input bit last);
    int n = 0;
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = last;
    while (!blk_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!blk_ready) begin
      fails++;
      $display("[TB] FAIL block accept: blk_ready=%0b after %0d cycles, required 1", blk_ready, n);
    end
    @(negedge clk);
    blk_valid = 1'b0;
    blk_last  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 16; i++) blk_data[32*i +: 32] = $urandom();
    checkOutput("busy after accept", 512'(busy), 512'(1));
    checkOutput("core_start after accept", 512'(core_start), 512'(1));
    checkOutput("blk_ready while running", 512'(blk_ready), 512'(0));
  endtask

  task automatic waitDigest();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL digest wait: %0d digests outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checkOutput("busy after handoff", 512'(busy), 512'(0));
    checkOutput("blk_ready after handoff", 512'(blk_ready), 512'(1));
  endtask

  // Reference: chain the standard IV through every block of the message.
  task automatic runMessage(input logic [511:0] blks[$], input logic [255:0] known,
                            input bit has_known, input int stall);
    logic [255:0] h = IV;
    foreach (blks[i]) begin
      iv_q.push_back(h);
      blk_q.push_back(blks[i]);
      h = sha_compress(h, blks[i]);
    end
    exp_q.push_back(has_known ? known : h);
    stall_len = stall;
    foreach (blks[i]) applyStimulus(blks[i], i == blks.size() - 1);
    waitDigest();
  endtask

  function automatic logic [511:0] randBlock();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [511:0] msg[$];
    int n;
    blk_valid = 1'b0;
    blk_data  = '0;
    blk_last  = 1'b0;
    doReset();

    core_lat = 5;
    msg = '{BLK_ABC};
    runMessage(msg, DIG_ABC, 1'b1, 0);

    core_lat = 7;
    msg = '{BLK_TWO_A, BLK_TWO_B};
    runMessage(msg, DIG_TWO, 1'b1, 2);

    core_lat = 3;
    msg = '{BLK_ABC};
    runMessage(msg, DIG_ABC, 1'b1, 10);
    msg = '{BLK_EMPTY};
    runMessage(msg, DIG_EMPTY, 1'b1, 10);

    for (int m = 0; m < 6; m++) begin
      msg.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) msg.push_back(randBlock());
      core_lat = $urandom_range(1, 10);
      runMessage(msg, '0, 1'b0, $urandom_range(0, 4));
    end

    // Latest completion that still fits inside the timeout window.
    core_lat = 13;
    msg = '{randBlock()};
    runMessage(msg, '0, 1'b0, 1);

    // One cycle later than that must time out instead of producing a digest.
    core_lat = 14;
    msg = '{randBlock()};
    iv_q.push_back(IV);
    blk_q.push_back(msg[0]);
    applyStimulus(msg[0], 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("late core error", 512'(error), 512'(1));
    checkOutput("late core digest_valid", 512'(digest_valid), 512'(0));
    doReset();

    // Core that never completes.
    core_lat = 0;
    msg = '{randBlock()};
    iv_q.push_back(IV);
    blk_q.push_back(msg[0]);
    applyStimulus(msg[0], 1'b1);
    n = 0;
    while (core_start && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("run cycles before timeout", 512'(n), 512'(TMO));
    blk_valid = 1'b1;
    repeat (5) begin
      checkOutput("timeout error", 512'(error), 512'(1));
      checkOutput("timeout core_start", 512'(core_start), 512'(0));
      checkOutput("timeout blk_ready", 512'(blk_ready), 512'(0));
      checkOutput("timeout digest_valid", 512'(digest_valid), 512'(0));
      @(negedge clk);
    end
    blk_valid = 1'b0;
    doReset();

    // Abort the two-block message part way through block 1, then resend it.
    core_lat = 8;
    iv_q.push_back(IV);
    blk_q.push_back(BLK_TWO_A);
    applyStimulus(BLK_TWO_A, 1'b0);
    repeat (3) @(negedge clk);
    doReset();
    core_lat = 4;
    msg = '{BLK_TWO_A, BLK_TWO_B};
    runMessage(msg, DIG_TWO, 1'b1, 3);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sha256_msg_ctrl.md
# sha256_msg_ctrl

Sequencing controller that feeds a multi-block SHA-256 message, one pre-padded 512-bit block at a time, into the single-block `SHA256top` core. It chains each block's result in as the next block's initial hash and presents the final 256-bit digest on a valid/ready output. It sits between a block source (DMA or host FIFO) and the core, and owns the core's `start_in`/`sha256_done` handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles allowed in RUN plus DRAIN for one block; exceeding it is an error.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `blk_valid`  in  1  source has a block.
- `blk_ready`  out  1  controller accepts a block this cycle.
- `blk_data`  in  512  padded block; word0 = `[511:480]`, word15 = `[31:0]`.
- `blk_last`  in  1  block is the final block of the message.
- `digest_valid`  out  1  `digest` is valid.
- `digest_ready`  in  1  sink accepts the digest.
- `digest`  out  256  final hash; H0 = `[255:224]`.
- `busy`  out  1  a message is in progress (block accepted, digest not yet taken).
- `error`  out  1  sticky core timeout.
- `core_start`  out  1  drives `SHA256top.start_in`.
- `core_block`  out  512  drives `w0_sha256`..`w15_sha256`.
- `core_iv`  out  256  drives `A_i`..`H_i` (A = `[255:224]`).
- `core_result`  in  256  from `sha256_result`.
- `core_done`  in  1  from `sha256_done`.

## Operation
- **State encoding:** IDLE, RUN, DRAIN, OUT, ERR.
- **Chain register** (256 bits):
  - Holds the standard IV `6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19` at reset and after every digest handoff.
  - `core_iv` = chain register at all times. The explicit IV is always driven; zero-default IV behaviour of the core is never relied on.
- **IDLE:**
  - `blk_ready`=1.
  - On `blk_valid&&blk_ready`: latch `blk_data` into `core_block`, latch `blk_last`, set `busy`=1, clear the timeout counter, go to RUN.
- **RUN:**
  - `core_start`=1, held until `core_done`=1 is sampled.
  - On that cycle: chain ← `core_result`, go to DRAIN (`core_start`=0 from the next cycle).
- **DRAIN:**
  - `core_start`=0; wait for `core_done`=0.
  - Then, if the latched last flag is set, go to OUT.
  - Otherwise return to IDLE with the chain retained and `busy` still 1.
- **OUT:**
  - `digest_valid`=1 and `digest`=chain, both stable until `digest_ready`.
  - On handshake: chain ← IV, `busy`=0, go to IDLE.
- **Timeout:**
  - The counter increments every cycle in RUN or DRAIN.
  - When it reaches `TIMEOUT_CYCLES`: go to ERR.
- **ERR:**
  - `error`=1, `core_start`=0, `blk_ready`=0, `digest_valid`=0.
  - Terminal until `reset`.
- **Output stability:** `core_block` is held unchanged from acceptance until the next acceptance.
- **Dropped inputs:** `blk_valid` outside IDLE is ignored; no data is dropped, because `blk_ready`=0.

## Timing
- **Reset values (asynchronous, immediate):**
  - state=IDLE, `blk_ready`=1, `core_start`=0, `digest_valid`=0, `busy`=0, `error`=0.
  - `digest`=0, `core_block`=0, `core_iv`=IV, counter=0.
- **Acceptance to start:** handshake at edge N → `core_start`=1 from N+1.
- **Core completion:** `core_done` first sampled high at edge M → chain updated at M, `core_start`=0 after M.
- **Final block:** `core_done` sampled low at edge K → `digest_valid`=1 after K.
- **Non-final block:** `core_done` sampled low at edge K → `blk_ready`=1 after K.
- **Overhead:** 3 cycles per block beyond core latency (accept, drain, output/return).
- **Back-to-back input:** the next block may be accepted the cycle `blk_ready` rises.
- **Reset mid-operation:**
  - Aborts the message immediately, chain returns to IV, `core_start` drops.
  - The first block after reset starts a new message.
- **`core_done` already high on entry to RUN:** treated as completion in that cycle (the core is expected to deassert only after `start_in` falls).
- **Timeout boundary:** the counter compares with `==`. A core finishing at exactly `TIMEOUT_CYCLES`-1 counted cycles succeeds.

## Test plan
Benches use the real `SHA256top` unless noted.
- **Single block:** single block "abc" (`61626380`, word15=`00000018`, `blk_last`=1) → one `digest_valid` with `ba7816bf…f20015ad`, `busy` falls after handshake.
- **Two blocks:**
  - Stimulus: two-block message "abcdbcdecdef…nopq" (56 bytes). Block 1 = data + `80000000`, word15=0, `blk_last`=0. Block 2 = zeros with word15=`000001c0`, `blk_last`=1.
  - Response: digest `248d6a61…19db06c1`. Exactly one `digest_valid` pulse train; `core_iv` during block 2 equals block 1's result.
- **Back-to-back messages with backpressure:** "abc" then "" (`80000000`, length 0), `digest_ready` held low 10 cycles on each.
  - `digest` stable while waiting.
  - Second digest `e3b0c442…7852b855`, proving the chain reverted to IV.
- **Busy rejection:** `blk_valid` held high while in RUN/DRAIN → `blk_ready`=0; block not consumed until IDLE; exactly one core run per block.
- **Timeout:** stub core with `core_done` stuck 0, `TIMEOUT_CYCLES`=16 → `error`=1 after 16 RUN cycles, `core_start`=0, `blk_ready`=0 until reset.
- **Reset mid-operation:**
  - Stimulus: `reset` pulsed mid-way through block 1 of the 56-byte message, then the full message is resent.
  - Response: reset values seen immediately; digest `248d6a61…19db06c1`.
